dmfb_multi_train_controller: RTL

//  N-channel DMFB train-move controller. Each channel independently sequences a next-move generator:

---
 rtl/dmfb_multi_train_controller.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dmfb_multi_train_controller.sv
// N independent droplet-train sequencers, each stepping a next-move generator and actuating
// electrodes for a programmable dwell. Define DMFB_WATCHDOG_EN for the gen_valid watchdog.
module dmfb_multi_train_controller #(
    parameter int unsigned NUM_TRAINS = 4,
    parameter int unsigned ELEC_W     = 8,
    parameter int unsigned DWELL_W    = 16,
    parameter int unsigned MOVE_W     = 8
`ifdef DMFB_WATCHDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES = 1024
`endif
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NUM_TRAINS-1:0]        start,
    input  logic [DWELL_W-1:0]           dwell_cycles,
    input  logic [NUM_TRAINS-1:0]        gen_dest,
    input  logic [NUM_TRAINS-1:0]        gen_valid,
    input  logic [NUM_TRAINS*ELEC_W-1:0] gen_elec,
    output logic [NUM_TRAINS-1:0]        gen_reset,
    output logic [NUM_TRAINS-1:0]        gen_next,
    output logic [NUM_TRAINS-1:0]        act_en,
    output logic [NUM_TRAINS*ELEC_W-1:0] act_elec,
    output logic [NUM_TRAINS-1:0]        busy,
    output logic [NUM_TRAINS-1:0]        done,
    output logic [NUM_TRAINS-1:0]        error,
    output logic [NUM_TRAINS*MOVE_W-1:0] move_count
);

    typedef enum logic [2:0] {
        StIdle,
        StResetGen,
        StReq,
        StNext,
        StWaitMove,
        StApply,
        StDone
    } state_e;

    state_e             state_q [NUM_TRAINS];
    state_e             state_d [NUM_TRAINS];
    logic [DWELL_W-1:0] dwell_q [NUM_TRAINS];
    logic [DWELL_W-1:0] dwell_d [NUM_TRAINS];
    logic [DWELL_W-1:0] cnt_q   [NUM_TRAINS];
    logic [DWELL_W-1:0] cnt_d   [NUM_TRAINS];
    logic [ELEC_W-1:0]  elec_q  [NUM_TRAINS];
    logic [ELEC_W-1:0]  elec_d  [NUM_TRAINS];
    logic [MOVE_W-1:0]  move_q  [NUM_TRAINS];
    logic [MOVE_W-1:0]  move_d  [NUM_TRAINS];

`ifdef DMFB_WATCHDOG_EN
    localparam int unsigned WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0]     wdog_q [NUM_TRAINS];
    logic [WDOG_W-1:0]     wdog_d [NUM_TRAINS];
    logic [NUM_TRAINS-1:0] err_q;
    logic [NUM_TRAINS-1:0] err_d;
`endif

    always_comb begin
`ifdef DMFB_WATCHDOG_EN
        err_d = err_q;
`endif
        for (int i = 0; i < NUM_TRAINS; i++) begin
            state_d[i] = state_q[i];
            dwell_d[i] = dwell_q[i];
            cnt_d[i]   = cnt_q[i];
            elec_d[i]  = elec_q[i];
            move_d[i]  = move_q[i];
`ifdef DMFB_WATCHDOG_EN
            wdog_d[i]  = wdog_q[i];
`endif
            if (!enable) begin
                // Global abort parks every active channel in DONE with its count frozen.
                if (state_q[i] != StIdle) begin
                    state_d[i] = StDone;
                end
            end else begin
                unique case (state_q[i])
                    StIdle, StDone: begin
                        if (start[i]) begin
                            state_d[i] = StResetGen;
                            dwell_d[i] = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
                            elec_d[i]  = '0;
                            move_d[i]  = '0;
`ifdef DMFB_WATCHDOG_EN
                            err_d[i]   = 1'b0;
`endif
                        end
                    end
                    StResetGen: state_d[i] = StReq;
                    StReq:      state_d[i] = gen_dest[i] ? StDone : StNext;
                    StNext: begin
                        state_d[i] = StWaitMove;
`ifdef DMFB_WATCHDOG_EN
                        wdog_d[i]  = '0;
`endif
                    end
                    StWaitMove: begin
                        if (gen_valid[i]) begin
                            state_d[i] = StApply;
                            elec_d[i]  = gen_elec[i*ELEC_W +: ELEC_W];
                            cnt_d[i]   = dwell_q[i];
`ifdef DMFB_WATCHDOG_EN
                        end else if (wdog_q[i] == WDOG_LAST) begin
                            state_d[i] = StDone;
                            err_d[i]   = 1'b1;
                        end else begin
                            wdog_d[i]  = wdog_q[i] + 1'b1;
`endif
                        end
                    end
                    StApply: begin
                        if (cnt_q[i] <= DWELL_W'(1)) begin
                            state_d[i] = StReq;
                            if (move_q[i] != '1) begin
                                move_d[i] = move_q[i] + 1'b1;
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i] - 1'b1;
                        end
                    end
                    default: state_d[i] = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_TRAINS; i++) begin
                state_q[i] <= StIdle;
                dwell_q[i] <= '0;
                cnt_q[i]   <= '0;
                elec_q[i]  <= '0;
                move_q[i]  <= '0;
`ifdef DMFB_WATCHDOG_EN
                wdog_q[i]  <= '0;
`endif
            end
`ifdef DMFB_WATCHDOG_EN
            err_q <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_TRAINS; i++) begin
                state_q[i] <= state_d[i];
                dwell_q[i] <= dwell_d[i];
                cnt_q[i]   <= cnt_d[i];
                elec_q[i]  <= elec_d[i];
                move_q[i]  <= move_d[i];
`ifdef DMFB_WATCHDOG_EN
                wdog_q[i]  <= wdog_d[i];
`endif
            end
`ifdef DMFB_WATCHDOG_EN
            err_q <= err_d;
`endif
        end
    end

    // Outputs are pure decodes of registered state.
    always_comb begin
        for (int i = 0; i < NUM_TRAINS; i++) begin
            gen_reset[i] = (state_q[i] == StResetGen);
            gen_next[i]  = (state_q[i] == StNext);
            act_en[i]    = (state_q[i] == StApply);
            busy[i]      = (state_q[i] != StIdle) && (state_q[i] != StDone);
            done[i]      = (state_q[i] == StDone);
            act_elec[i*ELEC_W +: ELEC_W]   = elec_q[i];
            move_count[i*MOVE_W +: MOVE_W] = move_q[i];
        end
    end

`ifdef DMFB_WATCHDOG_EN
    assign error = err_q;
`else
    assign error = '0;
`endif

endmodule
